grs_normalizer: RTL
===================

# grs_normalizer

Iterative post-add normalizer that produces the guard/round/sticky-extended significand consumed by the rounding stage. It accepts a raw adder/subtractor result with a carry bit and biased exponent. It shifts one position per cycle until the hidden bit sits at bit SIG_BITS+3, folding shifted-out bits into sticky. It emits a normalized `{hidden, fraction, G, R, S}` word plus adjusted exponent and status flags. It sits between the significand adder and the rounding block in the FP add/sub datapath, with valid/ready handshakes on both sides.

## Interface
- `SIG_BITS`, 23: fraction width.
- `EXP_BITS`, 8: biased exponent width.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block can accept input.
- `in_sign` in 1: sign, passed through unchanged.
- `in_exp` in EXP_BITS: biased exponent of raw result.
- `in_sig` in SIG_BITS+5: `{carry, hidden, fraction, G, R, S}`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `out_sign` out 1: registered sign.
- `out_exp` out EXP_BITS: adjusted biased exponent.
- `out_sig` out SIG_BITS+4: normalized `{hidden, fraction, G, R, S}`, the rounding stage input format.
- `out_zero` out 1: significand was zero.
- `out_denorm` out 1: result is subnormal, with `out_exp` equal to 0.
- `out_ovf` out 1: exponent reached all-ones.

## Operation
- FSM states are IDLE, SHIFT and DONE. The state is the only control; no counters are needed beyond the exponent register.
- **IDLE.** `in_ready`=1. On `in_valid && in_ready`:
  - load the sig, exp and sign registers;
  - an `in_exp` of 0 is loaded as 1, because a subnormal input has effective exponent 1;
  - go to SHIFT.
- **SHIFT.** Each cycle, evaluate the registers in priority order:
  1. **Carry set.** Right-shift by one. The new bit 0 is the OR of old bits 1 and 0, so sticky is preserved. Increment the exponent. If the new exponent is all-ones, set `ovf`. Go to DONE.
  2. **Zero significand.** Set `zero`, set exponent to 0, go to DONE.
  3. **Bit SIG_BITS+3 set.** Already normalized; go to DONE with no shift.
  4. **Exponent equals 1.** Set `denorm`, set exponent to 0, leave the significand as is, go to DONE.
  5. **Otherwise.** Left-shift by one with 0 entering bit 0, decrement the exponent, stay in SHIFT.
- **DONE.** `out_valid`=1 and outputs are held stable. On `out_ready`, go to IDLE. `in_ready`=0 in this state.
- `out_sig` is the low SIG_BITS+4 bits of the significand register. The carry bit is always 0 once the block reaches DONE.
- Status flags are cleared on every input accept.

## Timing
- Input accepted at edge T. `out_valid` rises at T+2+k, where k is the number of left shifts.
  - k=0 for inputs that are already normalized, carry, zero, or subnormal at entry.
  - Maximum k is SIG_BITS+3.
- A new input is accepted at the earliest in the cycle after the `out_valid && out_ready` handshake. Throughput is at most one result per k+3 cycles.
- `in_ready` is combinational from state only. It has no path from `out_ready`.
- A low `out_ready` stalls in DONE indefinitely with outputs stable.
- **Reset.** Reset is asynchronous and can occur in any state. It forces:
  - state IDLE, so `in_ready`=1;
  - `out_valid`=0;
  - `out_sign`, `out_exp`, `out_sig`, `out_zero`, `out_denorm` and `out_ovf` all 0.
- A transaction in flight at reset is discarded; no partial result is emitted.
- The exponent decrement never wraps, because the exponent-equals-1 check precedes the shift. The increment saturates to exactly all-ones and sets `ovf`.

## Structure
- `SIG_BITS` and `EXP_BITS` belong in the shared FP package.
- The shared FP package also holds:
  - the `norm_state_t` enum (IDLE, SHIFT, DONE);
  - a packed `grs_sig_t` struct of width SIG_BITS+4 shared with the rounding stage;
  - the `EXP_MAX` constant (all-ones).
- No sub-module is required. The single-step shift/sticky logic is one always_comb beside one always_ff. The parent datapath instantiates this block directly ahead of the rounding stage.

## Test plan
- **Already normalized.** `in_sig`=28'h4000000, `in_exp`=8'h80 -> `out_sig`=27'h4000000, `out_exp`=8'h80, `out_valid` at T+2.
- **Carry.** `in_sig`=28'h8000005, `in_exp`=8'h80 -> `out_sig`=27'h4000003 (sticky kept), `out_exp`=8'h81, `out_valid` at T+2.
- **Cancellation.** `in_sig`=28'h0100000, `in_exp`=8'h80 -> six shifts, `out_sig`=27'h4000000, `out_exp`=8'h7A, `out_valid` at T+8.
- **Subnormal and zero.** `in_sig`=28'h0000008, `in_exp`=8'h03 -> `out_sig`=27'h0000020, `out_exp`=0, `out_denorm`=1 at T+4. `in_sig`=0 -> `out_zero`=1, `out_exp`=0 at T+2.
- **Overflow.** `in_sig`=28'h8000000, `in_exp`=8'hFE -> `out_exp`=8'hFF, `out_ovf`=1, `out_sig`=27'h4000000.
- **Backpressure and reset.**
  - Hold `out_ready`=0 for 10 cycles -> outputs stable and `in_ready`=0 throughout.
  - Assert `rst_n`=0 mid-SHIFT -> all outputs 0 and `in_ready`=1 immediately.
  - The next input after reset completes normally.

Source files
------------

// File: rtl/grs_normalizer_pkg.sv
// Shared FP datapath definitions for the add/sub normalizer and rounding stage.
//   SIG_BITS  : fraction width
//   EXP_BITS  : biased exponent width
//   EXP_MAX   : all-ones exponent (infinity / overflow marker)
//   norm_state_t : normalizer FSM states
//   grs_sig_t : {hidden, fraction, guard, round, sticky} rounding-stage input word
package grs_normalizer_pkg;

  localparam int unsigned SIG_BITS = 23;
  localparam int unsigned EXP_BITS = 8;

  localparam logic [EXP_BITS-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } norm_state_t;

  typedef struct packed {
    logic                hidden;
    logic [SIG_BITS-1:0] fraction;
    logic                guard;
    logic                round;
    logic                sticky;
  } grs_sig_t;

endpackage

// File: rtl/grs_normalizer_if.sv
// Handshake/data bundle between the significand adder, the normalizer and the
// rounding stage.
//   in_*  : raw adder result {carry, hidden, fraction, G, R, S} with valid/ready
//   out_* : normalized GRS word, exponent and status flags with valid/ready
// Modports: master = upstream/downstream environment, slave = normalizer.
interface grs_normalizer_if;
  import grs_normalizer_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [EXP_BITS-1:0] in_exp;
  logic [SIG_BITS+4:0] in_sig;

  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic [EXP_BITS-1:0] out_exp;
  grs_sig_t            out_sig;
  logic                out_zero;
  logic                out_denorm;
  logic                out_ovf;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_sig,
           out_zero, out_denorm, out_ovf
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_sig,
           out_zero, out_denorm, out_ovf
  );

endinterface

// File: rtl/grs_normalizer.sv
// Iterative post-add normalizer. Shifts the raw significand one position per
// cycle until the hidden bit reaches bit SIG_BITS+3, folding shifted-out bits
// into sticky, and emits {hidden, fraction, G, R, S} with adjusted exponent.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : grs_normalizer_if slave (input and output valid/ready sides)
module grs_normalizer
  import grs_normalizer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  grs_normalizer_if.slave   bus
);

  localparam int unsigned CARRY_BIT  = SIG_BITS + 4;
  localparam int unsigned HIDDEN_BIT = SIG_BITS + 3;

  norm_state_t         state_q, state_d;
  logic [SIG_BITS+4:0] sig_q,   sig_d;
  logic [EXP_BITS-1:0] exp_q,   exp_d;
  logic                sign_q,  sign_d;
  logic                zero_q,  zero_d;
  logic                denorm_q, denorm_d;
  logic                ovf_q,   ovf_d;
  logic [EXP_BITS-1:0] exp_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sig_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    ovf_d    = ovf_q;
    // Saturating increment: an all-ones exponent stays all-ones.
    exp_inc  = (exp_q == EXP_MAX) ? EXP_MAX : exp_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sig_d    = bus.in_sig;
          // Subnormal inputs carry an effective exponent of 1.
          exp_d    = (bus.in_exp == '0) ? EXP_BITS'(1) : bus.in_exp;
          sign_d   = bus.in_sign;
          zero_d   = 1'b0;
          denorm_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (sig_q[CARRY_BIT]) begin
          // Right shift; the dropped bit is ORed into sticky.
          sig_d   = {1'b0, sig_q[CARRY_BIT:2], sig_q[1] | sig_q[0]};
          exp_d   = exp_inc;
          ovf_d   = (exp_inc == EXP_MAX);
          state_d = DONE;
        end else if (sig_q == '0) begin
          zero_d  = 1'b1;
          exp_d   = '0;
          state_d = DONE;
        end else if (sig_q[HIDDEN_BIT]) begin
          state_d = DONE;
        end else if (exp_q == EXP_BITS'(1)) begin
          // Checked before the left shift so the exponent never wraps.
          denorm_d = 1'b1;
          exp_d    = '0;
          state_d  = DONE;
        end else begin
          sig_d = {sig_q[CARRY_BIT-1:0], 1'b0};
          exp_d = exp_q - 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_sign   = sign_q;
  assign bus.out_exp    = exp_q;
  assign bus.out_sig    = sig_q[HIDDEN_BIT:0];
  assign bus.out_zero   = zero_q;
  assign bus.out_denorm = denorm_q;
  assign bus.out_ovf    = ovf_q;

endmodule
